// File: rtl/pairing_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : pairing_result_reader
// Purpose  : Drains the pairing core's 1200-bit result through the core's
//            slice-select interface. After core_done rises, it steps core_sel
//            through every slice and captures each slice. It then streams the
//            slice as WORD_W-bit words, least-significant word first, over a
//            valid/ready interface.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-low reset
//            core_done  - core finished (level)
//            core_out   - currently selected slice (combinational from core)
//            core_sel   - slice select driven to the core
//            out_valid  - output word valid
//            out_ready  - downstream accepts the word
//            out_data   - output word
//            out_first  - first word of the result (slice 0, word 0)
//            out_last   - last word of the result (last slice, last word)
//            busy       - readout in progress
//            abort      - one-cycle pulse: readout cancelled by core_done low
// Revision : 1.0 - initial release
// ============================================================================
module pairing_result_reader #(
    parameter int SLICE_W = 150,
    parameter int NSLICE  = 8,
    parameter int WORD_W  = 32,
    parameter int WPS     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               core_done,
    input  logic [SLICE_W-1:0] core_out,
    output logic [2:0]         core_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_first,
    output logic               out_last,
    output logic               busy,
    output logic               abort
);

    localparam int c_IDX_W = (WPS > 1) ? $clog2(WPS) : 1;
    localparam int c_PAD_W = WPS * WORD_W;

    localparam logic [c_IDX_W-1:0] c_LAST_WORD = c_IDX_W'(WPS - 1);
    localparam logic [2:0]         c_LAST_SEL  = 3'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_armed;
    logic [c_IDX_W-1:0]   r_word_idx;
    logic [SLICE_W-1:0]   r_buf;

    // Word idx of a slice; the top word is zero-extended past SLICE_W.
    function automatic logic [WORD_W-1:0] f_word(input logic [SLICE_W-1:0] s,
                                                 input logic [c_IDX_W-1:0] idx);
        logic [c_PAD_W-1:0] p;
        p              = '0;
        p[SLICE_W-1:0] = s;
        return p[int'(idx)*WORD_W +: WORD_W];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_armed    <= 1'b1;
            r_word_idx <= '0;
            r_buf      <= '0;
            core_sel   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            abort      <= 1'b0;
        end else begin
            abort <= 1'b0;
            if (r_state != ST_IDLE && !core_done) begin
                // Core was reset under us: drop the partial result and re-arm
                // so the next done edge gives a fresh, complete readout.
                r_state    <= ST_IDLE;
                r_armed    <= 1'b1;
                r_word_idx <= '0;
                core_sel   <= '0;
                out_valid  <= 1'b0;
                out_first  <= 1'b0;
                out_last   <= 1'b0;
                busy       <= 1'b0;
                abort      <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (core_done) begin
                            // Level-sensitive done: only one readout per rise.
                            if (r_armed) begin
                                core_sel   <= '0;
                                r_word_idx <= '0;
                                r_armed    <= 1'b0;
                                busy       <= 1'b1;
                                r_state    <= ST_SEL;
                            end
                        end else begin
                            r_armed <= 1'b1;
                        end
                    end

                    ST_SEL: begin
                        // core_sel has been stable a full cycle; core_out is settled.
                        r_buf     <= core_out;
                        out_valid <= 1'b1;
                        out_data  <= f_word(core_out, '0);
                        out_first <= (core_sel == 3'd0);
                        out_last  <= (core_sel == c_LAST_SEL) && (c_LAST_WORD == '0);
                        r_state   <= ST_SEND;
                    end

                    ST_SEND: begin
                        if (out_valid && out_ready) begin
                            if (r_word_idx != c_LAST_WORD) begin
                                r_word_idx <= r_word_idx + c_IDX_W'(1);
                                out_data   <= f_word(r_buf, r_word_idx + c_IDX_W'(1));
                                out_first  <= 1'b0;
                                out_last   <= (core_sel == c_LAST_SEL) &&
                                              (r_word_idx + c_IDX_W'(1) == c_LAST_WORD);
                            end else if (core_sel != c_LAST_SEL) begin
                                core_sel   <= core_sel + 3'd1;
                                r_word_idx <= '0;
                                out_valid  <= 1'b0;
                                out_first  <= 1'b0;
                                out_last   <= 1'b0;
                                r_state    <= ST_SEL;
                            end else begin
                                core_sel   <= '0;
                                r_word_idx <= '0;
                                out_valid  <= 1'b0;
                                out_first  <= 1'b0;
                                out_last   <= 1'b0;
                                busy       <= 1'b0;
                                r_armed    <= 1'b0;
                                r_state    <= ST_IDLE;
                            end
                        end
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pairing_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pairing_result_reader
// Purpose  : Self-checking bench for pairing_result_reader. A small core model
//            serves slices from an array, and the expected word stream is
//            derived from the slice contents by shifting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pairing_result_reader;

    localparam int SLICE_W = 150;
    localparam int NSLICE  = 8;
    localparam int WORD_W  = 32;
    localparam int WPS     = 5;
    localparam int NWORDS  = NSLICE * WPS;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               core_done = 1'b0;
    logic               out_ready = 1'b0;
    logic [SLICE_W-1:0] core_out;
    logic [2:0]         core_sel;
    logic               out_valid;
    logic [WORD_W-1:0]  out_data;
    logic               out_first;
    logic               out_last;
    logic               busy;
    logic               abort;

    logic [SLICE_W-1:0] slices [NSLICE];

    always #5 clk = ~clk;

    assign core_out = slices[core_sel];

    pairing_result_reader #(
        .SLICE_W(SLICE_W), .NSLICE(NSLICE), .WORD_W(WORD_W), .WPS(WPS)
    ) dut (
        .clk(clk), .reset(reset), .core_done(core_done), .core_out(core_out),
        .core_sel(core_sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_first(out_first), .out_last(out_last),
        .busy(busy), .abort(abort)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          e0 = 0;
    int          rdy_mode = 0;
    int          pat_i = 0;
    bit          rec_en = 1'b0;
    bit          stalled = 1'b0;
    logic [31:0] prev_data;
    logic        prev_first, prev_last;

    logic [31:0] q_data [$];
    bit          q_first [$];
    bit          q_last [$];
    int          q_edge [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [SLICE_W-1:0] rand_slice();
        logic [WPS*32-1:0] r;
        for (int i = 0; i < WPS; i++) r[32*i +: 32] = $urandom;
        return r[SLICE_W-1:0];
    endfunction

    // Reference: word j is bits [32k +: 32] of slice j/WPS, k = j%WPS.
    function automatic logic [31:0] exp_word(input int j);
        logic [SLICE_W-1:0] sh;
        sh = slices[j / WPS] >> (WORD_W * (j % WPS));
        return sh[31:0];
    endfunction

    // One clock: sample after the rising edge, choose ready for the next
    // edge, and log the word that will transfer on it.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (stalled) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, prev_data);
            check("stall_first", out_first, prev_first);
            check("stall_last", out_last, prev_last);
        end
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1: begin
                out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
                pat_i++;
            end
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        stalled    = out_valid && !out_ready;
        prev_data  = out_data;
        prev_first = out_first;
        prev_last  = out_last;
        if (rec_en && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_first.push_back(out_first);
            q_last.push_back(out_last);
            q_edge.push_back(cyc + 1);
        end
    endtask

    task automatic clear_log();
        q_data.delete(); q_first.delete(); q_last.delete(); q_edge.delete();
    endtask

    task automatic start();
        core_done = 1'b1;
        e0 = cyc + 1;
        clear_log();
    endtask

    task automatic collect(input int budget, output int end_cyc);
        int n;
        n = 0;
        end_cyc = -1;
        rec_en = 1'b1;
        while (n < budget) begin
            tick();
            n++;
            if (q_data.size() >= NWORDS && !busy) begin
                end_cyc = cyc;
                break;
            end
        end
        rec_en = 1'b0;
        if (end_cyc < 0) check("readout_timeout", 0, 1);
    endtask

    task automatic compare_result(input string tag);
        check({tag, "_count"}, q_data.size(), NWORDS);
        for (int j = 0; j < q_data.size() && j < NWORDS; j++) begin
            check({tag, "_data"}, q_data[j], exp_word(j));
            check({tag, "_first"}, q_first[j], (j == 0));
            check({tag, "_last"}, q_last[j], (j == NWORDS - 1));
        end
    endtask

    initial begin
        int end_cyc;
        int n;
        int busy_seen;
        int aborts;

        for (int s = 0; s < NSLICE; s++) slices[s] = SLICE_W'(16 + s);

        // Reset state
        repeat (2) tick();
        check("rst_core_sel", core_sel, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_first", out_first, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_abort", abort, 0);
        reset = 1'b1;
        tick();

        // Basic readout, ready held high, with latency checks
        rdy_mode = 0;
        start();
        collect(400, end_cyc);
        compare_result("t1");
        if (q_edge.size() == NWORDS) begin
            check("t1_first_edge", q_edge[0] - e0, 2);
            check("t1_last_edge", q_edge[NWORDS-1] - e0, 48);
        end
        check("t1_busy_fall", end_cyc - e0, 48);

        // Same data with ready pattern 1,0,0,1
        core_done = 1'b0;
        tick();
        rdy_mode = 1;
        pat_i = 0;
        start();
        collect(600, end_cyc);
        compare_result("t2");

        // Random slices, slice 3 all ones, random ready
        for (int s = 0; s < NSLICE; s++) slices[s] = rand_slice();
        slices[3] = '1;
        core_done = 1'b0;
        tick();
        rdy_mode = 2;
        start();
        collect(800, end_cyc);
        compare_result("t3");
        if (q_data.size() == NWORDS) begin
            for (int j = 15; j < 19; j++) check("t3_ones_word", q_data[j], 32'hFFFF_FFFF);
            check("t3_ones_top", q_data[19], 32'h003F_FFFF);
        end

        // Done held high: no rerun. Then a 1-cycle drop gives one more.
        rdy_mode = 0;
        clear_log();
        busy_seen = 0;
        rec_en = 1'b1;
        repeat (200) begin
            tick();
            if (busy) busy_seen++;
        end
        rec_en = 1'b0;
        check("t4_no_rerun_words", q_data.size(), 0);
        check("t4_no_rerun_busy", busy_seen, 0);
        core_done = 1'b0;
        tick();
        start();
        collect(400, end_cyc);
        compare_result("t4");

        // Abort after word 12, then restart from the top
        for (int s = 0; s < NSLICE; s++) slices[s] = rand_slice();
        core_done = 1'b0;
        tick();
        start();
        rec_en = 1'b1;
        n = 0;
        while (q_data.size() < 13 && n < 200) begin
            tick();
            n++;
        end
        rec_en = 1'b0;
        check("t5_words_before_drop", q_data.size(), 13);
        for (int j = 0; j < q_data.size(); j++) check("t5_partial_data", q_data[j], exp_word(j));
        tick();
        core_done = 1'b0;
        tick();
        check("t5_abort", abort, 1);
        check("t5_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_core_sel", core_sel, 0);
        check("t5_first", out_first, 0);
        check("t5_last", out_last, 0);
        aborts = abort ? 1 : 0;
        repeat (10) begin
            tick();
            if (abort) aborts++;
        end
        check("t5_abort_pulses", aborts, 1);
        start();
        collect(400, end_cyc);
        compare_result("t5_restart");

        // Asynchronous reset in slice 5, release with done high
        core_done = 1'b0;
        tick();
        start();
        rec_en = 1'b1;
        n = 0;
        while (q_data.size() < 27 && n < 300) begin
            tick();
            n++;
        end
        rec_en = 1'b0;
        check("t6_reached_slice5", q_data.size(), 27);
        check("t6_in_slice5", core_sel, 5);
        #2;
        reset = 1'b0;
        stalled = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_data", out_data, 0);
        check("t6_async_sel", core_sel, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_first", out_first, 0);
        check("t6_async_last", out_last, 0);
        tick();
        tick();
        reset = 1'b1;
        e0 = cyc + 1;
        clear_log();
        collect(400, end_cyc);
        compare_result("t6");
        if (q_edge.size() > 0) check("t6_first_edge", q_edge[0] - e0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
